// File: rtl/reorder_buffer_pkg.sv
// Shared widths and the entry record for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_IX_W  = 3;
  localparam int XLEN      = 32;
  localparam int REG_IX_W  = 5;

  typedef struct packed {
    logic                busy;
    logic                ready;
    logic [REG_IX_W-1:0] dest;
    logic [XLEN-1:0]     value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order CDB completion, in-order commit.
// Optional macro ROB_FLUSH_EN adds a flush_in port that empties the buffer.
module reorder_buffer #(
  parameter int ROB_DEPTH = reorder_buffer_pkg::ROB_DEPTH
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
`ifdef ROB_FLUSH_EN
  input  logic                                  flush_in,
`endif
  input  logic                                  alloc_valid_in,
  input  logic [reorder_buffer_pkg::REG_IX_W-1:0] alloc_dest_in,
  output logic                                  alloc_ready_out,
  output logic [reorder_buffer_pkg::ROB_IX_W-1:0] alloc_rob_ix_out,
  input  logic [reorder_buffer_pkg::ROB_IX_W-1:0] src1_rob_ix_in,
  input  logic [reorder_buffer_pkg::ROB_IX_W-1:0] src2_rob_ix_in,
  output logic                                  src1_ready_out,
  output logic                                  src2_ready_out,
  output logic [reorder_buffer_pkg::XLEN-1:0]   src1_value_out,
  output logic [reorder_buffer_pkg::XLEN-1:0]   src2_value_out,
  input  logic                                  cdb_valid_in,
  input  logic [reorder_buffer_pkg::ROB_IX_W-1:0] cdb_rob_ix_in,
  input  logic [reorder_buffer_pkg::XLEN-1:0]   cdb_value_in,
  output logic                                  commit_valid_out,
  output logic [reorder_buffer_pkg::REG_IX_W-1:0] commit_dest_out,
  output logic [reorder_buffer_pkg::XLEN-1:0]   commit_value_out,
  output logic [reorder_buffer_pkg::ROB_IX_W-1:0] commit_rob_ix_out,
  output logic [reorder_buffer_pkg::ROB_IX_W:0] count_out
);
  import reorder_buffer_pkg::ROB_IX_W;
  import reorder_buffer_pkg::XLEN;
  import reorder_buffer_pkg::REG_IX_W;
  import reorder_buffer_pkg::rob_entry_t;

  logic [ROB_DEPTH-1:0] r_busy;
  logic [ROB_DEPTH-1:0] r_ready;
  logic [REG_IX_W-1:0]  r_dest  [ROB_DEPTH];
  logic [XLEN-1:0]      r_value [ROB_DEPTH];

  logic [ROB_IX_W-1:0]  r_head;
  logic [ROB_IX_W-1:0]  r_tail;
  logic [ROB_IX_W:0]    r_count;

  logic                 r_commit_valid;
  logic [REG_IX_W-1:0]  r_commit_dest;
  logic [XLEN-1:0]      r_commit_value;
  logic [ROB_IX_W-1:0]  r_commit_ix;

  logic                 w_flush;
  logic                 w_full;
  logic                 w_alloc;
  logic                 w_cdb_hit;
  logic                 w_commit;
  logic                 w_src1_fwd;
  logic                 w_src2_fwd;
  rob_entry_t           w_head_entry;

`ifdef ROB_FLUSH_EN
  assign w_flush = flush_in;
`else
  assign w_flush = 1'b0;
`endif

  // Allocation handshake: a slot is taken on a rising edge where alloc_valid_in
  // and alloc_ready_out are both high; ready looks only at the registered count,
  // so a slot freed by a same-cycle commit is not reusable until the next cycle.
  assign w_full           = (r_count == (ROB_IX_W + 1)'(ROB_DEPTH));
  assign alloc_ready_out  = !w_full;
  assign alloc_rob_ix_out = r_tail;
  assign w_alloc          = alloc_valid_in && !w_full && !w_flush;

  assign w_cdb_hit = cdb_valid_in && r_busy[cdb_rob_ix_in] && !w_flush;

  always_comb begin
    w_head_entry       = '0;
    w_head_entry.busy  = r_busy[r_head];
    w_head_entry.ready = r_ready[r_head];
    w_head_entry.dest  = r_dest[r_head];
    w_head_entry.value = r_value[r_head];
  end

  assign w_commit = w_head_entry.busy && w_head_entry.ready && !w_flush;

  // A broadcast in the same cycle beats the stored copy.
  assign w_src1_fwd     = cdb_valid_in && (cdb_rob_ix_in == src1_rob_ix_in);
  assign w_src2_fwd     = cdb_valid_in && (cdb_rob_ix_in == src2_rob_ix_in);
  assign src1_ready_out = w_src1_fwd || (r_busy[src1_rob_ix_in] && r_ready[src1_rob_ix_in]);
  assign src2_ready_out = w_src2_fwd || (r_busy[src2_rob_ix_in] && r_ready[src2_rob_ix_in]);
  assign src1_value_out = w_src1_fwd ? cdb_value_in : r_value[src1_rob_ix_in];
  assign src2_value_out = w_src2_fwd ? cdb_value_in : r_value[src2_rob_ix_in];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_busy         <= '0;
      r_ready        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_dest  <= '0;
      r_commit_value <= '0;
      r_commit_ix    <= '0;
    end else if (w_flush) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_busy         <= '0;
      r_ready        <= '0;
      r_commit_valid <= 1'b0;
    end else begin
      r_commit_valid <= w_commit;
      if (w_cdb_hit) begin
        r_ready[cdb_rob_ix_in] <= 1'b1;
      end
      if (w_alloc) begin
        r_busy[r_tail]  <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_tail          <= r_tail + 1'b1;
      end
      // Commit is last so it wins over a redundant CDB hit on the head.
      if (w_commit) begin
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
        r_commit_dest   <= w_head_entry.dest;
        r_commit_value  <= w_head_entry.value;
        r_commit_ix     <= r_head;
      end
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_alloc) begin
      r_dest[r_tail] <= alloc_dest_in;
    end
    if (w_cdb_hit) begin
      r_value[cdb_rob_ix_in] <= cdb_value_in;
    end
  end

  assign commit_valid_out  = r_commit_valid;
  assign commit_dest_out   = r_commit_dest;
  assign commit_value_out  = r_commit_value;
  assign commit_rob_ix_out = r_commit_ix;
  assign count_out         = r_count;

endmodule
